// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FCNT  = 2'd3;

  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel source: (pattern, x, y, frame count) -> pixel.
module dvp_pattern_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] frame_cnt,
  output logic [15:0] pixel
);

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [15:0] bar;
  logic        unused_bits;

  assign unused_bits = ^{y[15:8], frame_cnt[15:8]};

  always_comb begin
    bar   = x / 16'(BAR_W);
    pixel = 16'h0000;
    case (pattern)
      // columns past the eighth bar (H_ACTIVE not a multiple of 8) stay black
      PAT_BARS:  pixel = (bar > 16'd7) ? BAR_RGB[7] : BAR_RGB[bar[2:0]];
      PAT_RAMP:  pixel = {x[4:0], x[5:0], x[4:0]};
      PAT_CHECK: pixel = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
      default:   pixel = {frame_cnt[7:0], y[7:0]};
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// Synthetic DVP camera: frame-timing FSM, h/v/div counters and registered outputs.
//   state  | meaning
//   IDLE   | no frame in flight, waiting for enable_i
//   VSYNC  | cmos_vsync high for VSYNC_LINES line periods
//   VBACK  | blank lines before the first active line
//   ACTIVE | V_ACTIVE lines of href/wr/data
//   VFRONT | blank lines; frame_done on the last clock
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 20,
  parameter int V_FRONT     = 10,
  parameter int PIX_DIV     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic        cmos_16bit_wr,
  output logic [15:0] cmos_16bit_data,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);

  localparam int LINE_CLKS = H_ACTIVE * PIX_DIV + H_BLANK;
  localparam int LT_W      = $clog2(LINE_CLKS);
  localparam int V_MAX1    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX2    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX     = (V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2;
  localparam int LN_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int X_W       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  state_e          state, state_d;
  logic [LT_W-1:0] line_tmr;
  logic [LN_W-1:0] lines_left;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [1:0]      div;
  logic [1:0]      pat_q;
  logic            line_end, frame_tc;
  logic            href_d, wr_d, done_d, start_d;
  logic [15:0]     pixel;

  function automatic logic [LN_W-1:0] lines_of(input state_e s);
    case (s)
      ST_VSYNC:  return LN_W'(VSYNC_LINES - 1);
      ST_VBACK:  return LN_W'(V_BACK - 1);
      ST_ACTIVE: return LN_W'(V_ACTIVE - 1);
      ST_VFRONT: return LN_W'(V_FRONT - 1);
      default:   return '0;
    endcase
  endfunction

  assign line_end = (line_tmr == '0);
  assign frame_tc = line_end && (lines_left == '0);
  // the first H_ACTIVE*PIX_DIV clocks of the down-counting line timer are active
  assign href_d   = (state == ST_ACTIVE) && (line_tmr >= LT_W'(H_BLANK));
  assign wr_d     = href_d && (div == 2'(PIX_DIV - 1));
  assign start_d  = (state_d == ST_VSYNC) && (state != ST_VSYNC);

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    case (state)
      ST_IDLE:   if (enable_i) state_d = ST_VSYNC;
      ST_VSYNC:  if (frame_tc) state_d = ST_VBACK;
      ST_VBACK:  if (frame_tc) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_tc) state_d = ST_VFRONT;
      ST_VFRONT: begin
        if (frame_tc) begin
          done_d  = 1'b1;
          state_d = enable_i ? ST_VSYNC : ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      line_tmr   <= LT_W'(LINE_CLKS - 1);
      lines_left <= '0;
      x          <= '0;
      y          <= '0;
      div        <= '0;
      pat_q      <= PAT_BARS;
    end else begin
      state <= state_d;
      if (state_d != state || state == ST_IDLE) begin
        line_tmr   <= LT_W'(LINE_CLKS - 1);
        lines_left <= lines_of(state_d);
        x          <= '0;
        y          <= '0;
        div        <= '0;
      end else if (line_end) begin
        line_tmr   <= LT_W'(LINE_CLKS - 1);
        lines_left <= lines_left - 1'b1;
        x          <= '0;
        div        <= '0;
        if (state == ST_ACTIVE) y <= y + 1'b1;
      end else begin
        line_tmr <= line_tmr - 1'b1;
        if (wr_d) begin
          x   <= x + 1'b1;
          div <= '0;
        end else if (href_d) begin
          div <= div + 1'b1;
        end
      end
      if (start_d) pat_q <= pattern_sel_i;
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .pattern   (pat_q),
    .x         (16'(x)),
    .y         (16'(y)),
    .frame_cnt (frame_cnt_o),
    .pixel     (pixel)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmos_vsync      <= 1'b0;
      cmos_href       <= 1'b0;
      cmos_16bit_wr   <= 1'b0;
      cmos_16bit_data <= '0;
      frame_done_o    <= 1'b0;
      frame_cnt_o     <= '0;
      busy_o          <= 1'b0;
    end else begin
      cmos_vsync    <= (state == ST_VSYNC);
      cmos_href     <= href_d;
      cmos_16bit_wr <= wr_d;
      if (wr_d) cmos_16bit_data <= pixel;
      frame_done_o  <= done_d;
      if (done_d) frame_cnt_o <= frame_cnt_o + 16'd1;
      busy_o        <= (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx with a tiny frame (8x4 pixels, 84-clock frame).
module tb_dvp_pattern_tx;

  localparam int FRAME  = 84;
  localparam int FRAME2 = 140;

  localparam logic [15:0] BARS_T [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [15:0] RAMP_T [8] = '{16'h0000, 16'h0821, 16'h1042, 16'h1863,
                                         16'h2084, 16'h28A5, 16'h30C6, 16'h38E7};

  logic        clk, rst, enable;
  logic [1:0]  sel;
  logic        vsync, href, wr, done, busy;
  logic [15:0] data, fcnt;

  logic        rst2, en2;
  logic [1:0]  sel2;
  logic        vsync2, href2, wr2, done2, busy2;
  logic [15:0] data2, fcnt2;

  int n_vec = 0;
  int n_mis = 0;

  int tim_bad, wr_cnt, done_at, done_cnt, wv_done, wv_href;
  logic [15:0] fc_at_done;
  logic [15:0] pix_q[$];

  dvp_pattern_tx #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PIX_DIV(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pattern_sel_i(sel),
    .cmos_vsync(vsync), .cmos_href(href), .cmos_16bit_wr(wr),
    .cmos_16bit_data(data), .frame_done_o(done), .frame_cnt_o(fcnt), .busy_o(busy)
  );

  dvp_pattern_tx #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PIX_DIV(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2), .enable_i(en2), .pattern_sel_i(sel2),
    .cmos_vsync(vsync2), .cmos_href(href2), .cmos_16bit_wr(wr2),
    .cmos_16bit_data(data2), .frame_done_o(done2), .frame_cnt_o(fcnt2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic [1:0] pat, input int i, input logic [7:0] fc);
    case (pat)
      2'd0:    return BARS_T[i % 8];
      2'd1:    return RAMP_T[i % 8];
      2'd2:    return 16'h0000;
      default: return {fc, 8'(i / 8)};
    endcase
  endfunction

  function automatic logic href_model(input int c, input int first, input int line, input int act);
    return (c >= first) && (c < first + 4 * line) && (((c - first) % line) < act);
  endfunction

  // Leaves the bench at the negedge where vsync is first seen high (cycle 1 of a frame).
  task automatic wait_vsync();
    wv_done = 0;
    wv_href = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vsync) return;
      wv_done += int'(done);
      wv_href += int'(href);
    end
    check_eq("vsync_start_timeout", 32'(vsync), 32'd1);
  endtask

  task automatic capture(input int drop_at, input int sel_at, input logic [1:0] new_sel);
    wait_vsync();
    tim_bad = 0; wr_cnt = 0; done_at = 0; done_cnt = 0; fc_at_done = 16'hDEAD;
    pix_q.delete();
    for (int c = 1; c <= FRAME; c++) begin
      if (c > 1) @(negedge clk);
      if (c == drop_at) enable = 1'b0;
      if (c == sel_at) sel = new_sel;
      if (vsync !== (c <= 12)) tim_bad++;
      if (href !== href_model(c, 25, 12, 8)) tim_bad++;
      if (wr) begin
        pix_q.push_back(data);
        if (!href) tim_bad++;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_at = c;
        fc_at_done = fcnt;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [1:0] pat, input logic [7:0] fc,
                             input logic [15:0] fc_done);
    int nbad;
    nbad = 0;
    foreach (pix_q[i]) if (pix_q[i] !== exp_pix(pat, i, fc)) nbad++;
    check_eq({tag, "_timing"}, 32'(tim_bad), 32'd0);
    check_eq({tag, "_wr_count"}, 32'(wr_cnt), 32'd32);
    check_eq({tag, "_pixels"}, 32'(nbad), 32'd0);
    check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_done_at"}, 32'(done_at), 32'd84);
    check_eq({tag, "_frame_cnt"}, 32'(fc_at_done), 32'(fc_done));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, bad2, w2, d2at;
    logic [15:0] p2[$];
    rst = 1'b1; enable = 1'b0; sel = 2'd0;
    rst2 = 1'b1; en2 = 1'b0; sel2 = 2'd0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check_eq("reset_outputs", {vsync, href, wr, done, busy, data}, 32'd0);
    check_eq("reset_frame_cnt", 32'(fcnt), 32'd0);
    rst = 1'b0;

    // colour bars from reset; enable dropped at clock 30
    capture(30, 0, 2'd0);
    check_frame("bars", 2'd0, 8'd0, 16'd1);
    @(negedge clk);
    check_eq("busy_after_stop", 32'(busy), 32'd0);
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      nv += int'(vsync) + int'(done);
    end
    check_eq("idle_no_vsync", 32'(nv), 32'd0);

    // checker frame, select changed mid-frame to ramp, then to frame-count
    sel = 2'd2;
    enable = 1'b1;
    capture(0, 30, 2'd1);
    check_frame("checker", 2'd2, 8'd0, 16'd2);
    capture(0, 30, 2'd3);
    check_frame("ramp", 2'd1, 8'd0, 16'd3);
    capture(40, 0, 2'd0);
    check_frame("fcnt", 2'd3, 8'd3, 16'd4);

    // reset during active line 2
    repeat (5) @(negedge clk);
    sel = 2'd0;
    enable = 1'b1;
    wait_vsync();
    repeat (51) @(negedge clk);
    check_eq("pre_reset_href", 32'(href), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midframe_reset_outputs", {vsync, href, wr, done, busy, data}, 32'd0);
    check_eq("midframe_reset_frame_cnt", 32'(fcnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    capture(0, 0, 2'd0);
    check_eq("restart_no_done", 32'(wv_done), 32'd0);
    check_eq("restart_no_href", 32'(wv_href), 32'd0);
    check_frame("restart", 2'd0, 8'd0, 16'd1);

    // frame counter wrap
    wait_vsync();
    force dut.frame_cnt_o = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_o;
    enable = 1'b0;
    nv = 0;
    for (int i = 0; i < 200 && nv == 0; i++) begin
      @(negedge clk);
      if (done) begin
        nv = 1;
        check_eq("frame_cnt_wrap", 32'(fcnt), 32'h0000);
      end
    end
    check_eq("wrap_done_seen", 32'(nv), 32'd1);

    // PIX_DIV = 2 instance
    @(negedge clk);
    rst2 = 1'b0;
    en2 = 1'b1;
    nv = 0;
    for (int i = 0; i < 300 && !vsync2; i++) @(negedge clk);
    check_eq("div2_vsync_start", 32'(vsync2), 32'd1);
    bad2 = 0; w2 = 0; d2at = 0;
    for (int c = 1; c <= FRAME2; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 50) en2 = 1'b0;
      if (vsync2 !== (c <= 20)) bad2++;
      if (href2 !== href_model(c, 41, 20, 16)) bad2++;
      if (wr2 !== (href_model(c, 41, 20, 16) && (((c - 41) % 20) % 2 == 1))) bad2++;
      if (wr2) begin
        p2.push_back(data2);
        w2++;
      end
      if (done2) d2at = c;
    end
    check_eq("div2_timing", 32'(bad2), 32'd0);
    check_eq("div2_wr_count", 32'(w2), 32'd32);
    bad2 = 0;
    foreach (p2[i]) if (p2[i] !== BARS_T[i % 8]) bad2++;
    check_eq("div2_pixels", 32'(bad2), 32'd0);
    check_eq("div2_done_at", 32'(d2at), 32'd140);
    check_eq("div2_frame_cnt", 32'(fcnt2), 32'd1);
    @(negedge clk);
    check_eq("div2_busy_after", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
